// File: rtl/alu_station_pkg.sv
// rtl/alu_station_pkg.sv - shared types, tags, op codes and operand wake helper for the ALU station
package alu_station_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [1:0]  regtag_t;
    typedef logic [3:0]  aluop_t;

    localparam regtag_t UNLOCKED   = 2'd0;
    localparam regtag_t ALU_MASTER = 2'd1;
    localparam regtag_t ALU_SALVER = 2'd2;
    localparam regtag_t LOAD_STORE = 2'd3;

    localparam aluop_t OP_ADD   = 4'd0;
    localparam aluop_t OP_SUB   = 4'd1;
    localparam aluop_t OP_SLL   = 4'd2;
    localparam aluop_t OP_SLT   = 4'd3;
    localparam aluop_t OP_SLTU  = 4'd4;
    localparam aluop_t OP_XOR   = 4'd5;
    localparam aluop_t OP_SRL   = 4'd6;
    localparam aluop_t OP_SRA   = 4'd7;
    localparam aluop_t OP_OR    = 4'd8;
    localparam aluop_t OP_AND   = 4'd9;
    localparam aluop_t OP_PASSY = 4'd10;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } station_state_e;

    typedef struct packed {
        regtag_t tag;
        word_t   data;
    } operand_t;

    // Each bus carries a fixed producer tag, so at most one bus can match a given operand.
    function automatic operand_t wake_operand(
        input operand_t o,
        input logic     en0,
        input word_t    d0,
        input logic     en1,
        input word_t    d1,
        input logic     enm,
        input word_t    dm
    );
        operand_t r;
        r = o;
        if (en0 && o.tag == ALU_MASTER) r = '{tag: UNLOCKED, data: d0};
        if (en1 && o.tag == ALU_SALVER) r = '{tag: UNLOCKED, data: d1};
        if (enm && o.tag == LOAD_STORE) r = '{tag: UNLOCKED, data: dm};
        return r;
    endfunction

endpackage

// File: rtl/alu_station_alu_core.sv
// rtl/alu_station_alu_core.sv - combinational integer ALU used by the station
module alu_core
    import alu_station_pkg::*;
(
    input  aluop_t op,
    input  word_t  x,
    input  word_t  y,
    output word_t  result
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = y[4:0];
        result = '0;
        case (op)
            OP_ADD:   result = x + y;
            OP_SUB:   result = x - y;
            OP_SLL:   result = x << shamt;
            OP_SLT:   result = {31'd0, $signed(x) < $signed(y)};
            OP_SLTU:  result = {31'd0, x < y};
            OP_XOR:   result = x ^ y;
            OP_SRL:   result = x >> shamt;
            OP_SRA:   result = word_t'($signed(x) >>> shamt);
            OP_OR:    result = x | y;
            OP_AND:   result = x & y;
            OP_PASSY: result = y;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_station.sv
// rtl/alu_station.sv - single-entry reservation station with ALU and write-back broadcast
module alu_station
    import alu_station_pkg::*;
#(
    parameter regtag_t MY_TAG = ALU_MASTER
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     en_disp,
    output logic     disp_ready,
    input  aluop_t   op,
    input  word_t    datax,
    input  word_t    datay,
    input  regtag_t  tagx,
    input  regtag_t  tagy,
    input  regaddr_t rd,
    input  logic     en_wb0,
    input  logic     en_wb1,
    input  logic     en_wbM,
    input  regaddr_t wb_addr0,
    input  regaddr_t wb_addr1,
    input  regaddr_t wb_addrM,
    input  word_t    wb_data0,
    input  word_t    wb_data1,
    input  word_t    wb_dataM,
    output logic     en_w,
    output regaddr_t reg_write_addr,
    output word_t    write_data
);

    station_state_e state_q, state_d;
    aluop_t         op_q, op_d;
    regaddr_t       rd_q, rd_d;
    operand_t       opx_q, opx_d, opy_q, opy_d;
    logic           en_w_q, en_w_d;
    regaddr_t       addr_q, addr_d;
    word_t          data_q, data_d;

    logic     accept;
    logic     both_ready;
    operand_t woke_x, woke_y;
    aluop_t   alu_op;
    word_t    alu_result;

    // Matching is by tag only; destination addresses on the snooped buses and our own tag
    // (used by dispatch to lock rd) play no part inside the station.
    logic unused_cfg;
    assign unused_cfg = ^{wb_addr0, wb_addr1, wb_addrM, MY_TAG};

    assign disp_ready = (state_q == ST_FREE) || (state_q == ST_DONE);

    always_comb begin
        accept     = rdy && en_disp && disp_ready;
        woke_x     = wake_operand(accept ? operand_t'{tag: tagx, data: datax} : opx_q,
                                  en_wb0, wb_data0, en_wb1, wb_data1, en_wbM, wb_dataM);
        woke_y     = wake_operand(accept ? operand_t'{tag: tagy, data: datay} : opy_q,
                                  en_wb0, wb_data0, en_wb1, wb_data1, en_wbM, wb_dataM);
        both_ready = (woke_x.tag == UNLOCKED) && (woke_y.tag == UNLOCKED);
        alu_op     = accept ? op : op_q;
    end

    alu_core u_alu_core (
        .op     (alu_op),
        .x      (woke_x.data),
        .y      (woke_y.data),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opx_d   = opx_q;
        opy_d   = opy_q;
        en_w_d  = en_w_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (rdy) begin
            en_w_d = 1'b0;
            if (accept) begin
                op_d  = op;
                rd_d  = rd;
                opx_d = woke_x;
                opy_d = woke_y;
            end
            if (accept || state_q == ST_WAIT) begin
                opx_d = woke_x;
                opy_d = woke_y;
                if (both_ready) begin
                    state_d = ST_DONE;
                    en_w_d  = 1'b1;
                    addr_d  = accept ? rd : rd_q;
                    data_d  = alu_result;
                end else begin
                    state_d = ST_WAIT;
                end
            end else begin
                state_d = ST_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FREE;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            opx_q   <= '{tag: UNLOCKED, data: '0};
            opy_q   <= '{tag: UNLOCKED, data: '0};
            en_w_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opx_q   <= opx_d;
            opy_q   <= opy_d;
            en_w_q  <= en_w_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign en_w           = en_w_q;
    assign reg_write_addr = addr_q;
    assign write_data     = data_q;

endmodule
